// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// state encoding, opcode/funct constants and ALU operation codes.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_RTYPE_EX,
      S_RTYPE_WB,
      S_MEM_ADR,
      S_MEM_RD,
      S_LW_WB,
      S_MEM_WR,
      S_BRANCH,
      S_ADDI_EX,
      S_ADDI_WB,
      S_JUMP,
      S_TRAP
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// R-type funct decoder: maps funct to an ALU operation code.
// Ports: funct_i in; alu_ctrl_o, funct_illegal_o out (combinational).
module alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0] funct_i,
   output logic [3:0] alu_ctrl_o,
   output logic       funct_illegal_o
);

   always_comb begin
      alu_ctrl_o      = ALU_ADD;
      funct_illegal_o = 1'b0;
      case (funct_i)
         FN_ADD:  alu_ctrl_o = ALU_ADD;
         FN_SUB:  alu_ctrl_o = ALU_SUB;
         FN_AND:  alu_ctrl_o = ALU_AND;
         FN_OR:   alu_ctrl_o = ALU_OR;
         FN_SLT:  alu_ctrl_o = ALU_SLT;
         default: funct_illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath with retired-instruction
// counter and illegal-instruction trap.
// Ports: clk, rst (async, active-high), opcode, funct, zero, mem_ready in;
// memory/IR/PC/ALU/register-file controls, illegal, instret out.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_ctrl,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_wr,
   output logic             illegal,
   output logic [CNT_W-1:0] instret
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              retire;
   logic [3:0]        rtype_alu;
   logic              funct_bad;

   logic       mr_c, mw_c, iod_c, irw_c, pce_c;
   logic [1:0] pcs_c, asb_c;
   logic       asa_c;
   logic [3:0] alu_c;
   logic       rdst_c, m2r_c, rw_c, ill_c;

   alu_decoder u_alu_dec (
      .funct_i         (funct),
      .alu_ctrl_o      (rtype_alu),
      .funct_illegal_o (funct_bad)
   );

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      mr_c    = 1'b0;
      mw_c    = 1'b0;
      iod_c   = 1'b0;
      irw_c   = 1'b0;
      pce_c   = 1'b0;
      pcs_c   = 2'b00;
      asa_c   = 1'b0;
      asb_c   = 2'b00;
      alu_c   = 4'b0000;
      rdst_c  = 1'b0;
      m2r_c   = 1'b0;
      rw_c    = 1'b0;
      ill_c   = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mr_c  = 1'b1;
            asb_c = 2'b01;
            alu_c = ALU_ADD;
            if (mem_ready) begin
               irw_c   = 1'b1;
               pce_c   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target computed here while the opcode is decoded.
            asb_c = 2'b11;
            alu_c = ALU_ADD;
            case (opcode)
               OP_RTYPE:      state_d = S_RTYPE_EX;
               OP_LW, OP_SW:  state_d = S_MEM_ADR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI:       state_d = S_ADDI_EX;
               OP_J:          state_d = S_JUMP;
               default:       state_d = S_TRAP;
            endcase
         end
         S_RTYPE_EX: begin
            asa_c   = 1'b1;
            alu_c   = rtype_alu;
            state_d = funct_bad ? S_TRAP : S_RTYPE_WB;
         end
         S_RTYPE_WB: begin
            rw_c   = 1'b1;
            rdst_c = 1'b1;
            retire = 1'b1;
         end
         S_MEM_ADR: begin
            asa_c   = 1'b1;
            asb_c   = 2'b10;
            alu_c   = ALU_ADD;
            state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mr_c  = 1'b1;
            iod_c = 1'b1;
            if (mem_ready) state_d = S_LW_WB;
         end
         S_LW_WB: begin
            rw_c   = 1'b1;
            m2r_c  = 1'b1;
            retire = 1'b1;
         end
         S_MEM_WR: begin
            mw_c  = 1'b1;
            iod_c = 1'b1;
            if (mem_ready) retire = 1'b1;
         end
         S_BRANCH: begin
            asa_c  = 1'b1;
            alu_c  = ALU_SUB;
            pcs_c  = 2'b01;
            pce_c  = (opcode == OP_BEQ) ? zero : ~zero;
            retire = 1'b1;
         end
         S_ADDI_EX: begin
            asa_c   = 1'b1;
            asb_c   = 2'b10;
            alu_c   = ALU_ADD;
            state_d = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            rw_c   = 1'b1;
            retire = 1'b1;
         end
         S_JUMP: begin
            pcs_c  = 2'b10;
            pce_c  = 1'b1;
            retire = 1'b1;
         end
         S_TRAP: begin
            ill_c = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
      if (retire) state_d = S_FETCH;
   end

   assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         instret_q <= instret_d;
      end
   end

   // Reset gates every control combinationally so an in-flight
   // write or register update dies the moment rst rises.
   assign mem_rd     = mr_c & ~rst;
   assign mem_wr     = mw_c & ~rst;
   assign i_or_d     = iod_c & ~rst;
   assign ir_write   = irw_c & ~rst;
   assign pc_en      = pce_c & ~rst;
   assign pc_src     = pcs_c & {2{~rst}};
   assign alu_src_a  = asa_c & ~rst;
   assign alu_src_b  = asb_c & {2{~rst}};
   assign alu_ctrl   = alu_c & {4{~rst}};
   assign reg_dst    = rdst_c & ~rst;
   assign mem_to_reg = m2r_c & ~rst;
   assign reg_wr     = rw_c & ~rst;
   assign illegal    = ill_c & ~rst;
   assign instret    = instret_q;

endmodule
